// File: rtl/keypad_time_loader_if.sv
// Bundle of keypad inputs and timer-load/display outputs for keypad_time_loader.
// The master side drives the keys; the slave side is the loader itself.
interface keypad_time_loader_if;
  logic [3:0] key_code;
  logic       key_down;
  logic       start_key;
  logic       clear_key;
  logic [3:0] data;
  logic       loadn;
  logic [3:0] entry_mins;
  logic [3:0] entry_tens;
  logic [3:0] entry_ones;
  logic       loading;
  logic       load_done;

  modport master (
    output key_code, key_down, start_key, clear_key,
    input  data, loadn, entry_mins, entry_tens, entry_ones, loading, load_done
  );

  modport slave (
    input  key_code, key_down, start_key, clear_key,
    output data, loadn, entry_mins, entry_tens, entry_ones, loading, load_done
  );
endinterface

// File: rtl/keypad_time_loader.sv
// Debounced keypad entry of an M:SS time and serial load of its three digits
// into the countdown timer (minutes first, loadn low for exactly three clocks).
module keypad_time_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input logic                 clock,
  input logic                 clrn,
  keypad_time_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD0 = 3'd1,
    S_LOAD1 = 3'd2,
    S_LOAD2 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DB_FULL = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Bit 0 = digit key, bit 1 = Start, bit 2 = Clear.
  logic [2:0]       w_keys;
  logic [CNT_W-1:0] w_cnt_nxt [3];
  logic [2:0]       w_rise;
  logic [CNT_W-1:0] r_cnt [3];
  logic [2:0]       r_last;
  logic [2:0]       r_level;
  logic [2:0]       r_press;
  logic [3:0]       r_code;

  state_t     r_state;
  logic [3:0] r_data;
  logic       r_loadn;
  logic [3:0] r_mins;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       r_loading;
  logic       r_load_done;

  assign w_keys = {bus.clear_key, bus.start_key, bus.key_down};

  // Run length of equal samples including this one, and debounced rising edges.
  always_comb begin
    w_rise = 3'b000;
    for (int k = 0; k < 3; k++) begin
      w_cnt_nxt[k] = CNT_ONE;
      if (w_keys[k] != r_last[k]) begin
        w_cnt_nxt[k] = CNT_ONE;
      end else if (r_cnt[k] < DB_FULL) begin
        w_cnt_nxt[k] = r_cnt[k] + CNT_ONE;
      end else begin
        w_cnt_nxt[k] = r_cnt[k];
      end
      w_rise[k] = (w_cnt_nxt[k] == DB_FULL) && w_keys[k] && !r_level[k];
    end
  end

  // Debouncer state; press pulses are registered and consumed one clock later.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      r_last  <= 3'b000;
      r_level <= 3'b000;
      r_press <= 3'b000;
      r_code  <= 4'd0;
      for (int k = 0; k < 3; k++) begin
        r_cnt[k] <= {CNT_W{1'b0}};
      end
    end else begin
      r_last  <= w_keys;
      r_press <= w_rise;
      for (int k = 0; k < 3; k++) begin
        r_cnt[k] <= w_cnt_nxt[k];
        if (w_cnt_nxt[k] == DB_FULL) begin
          r_level[k] <= w_keys[k];
        end
      end
      if (w_rise[0]) begin
        r_code <= bus.key_code;
      end
    end
  end

  // Entry register and load sequencer; presses outside IDLE are dropped.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      r_state     <= S_IDLE;
      r_data      <= 4'd0;
      r_loadn     <= 1'b1;
      r_mins      <= 4'd0;
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
      r_loading   <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_load_done <= 1'b0;
          if (r_press[2]) begin
            r_mins <= 4'd0;
            r_tens <= 4'd0;
            r_ones <= 4'd0;
          end else if (r_press[1] && ((r_mins | r_tens | r_ones) != 4'd0)) begin
            r_state   <= S_LOAD0;
            r_loadn   <= 1'b0;
            r_data    <= r_mins;
            r_loading <= 1'b1;
            // Seconds-tens above 5 is not a valid time; saturate to x:59.
            if (r_tens > 4'd5) begin
              r_tens <= 4'd5;
              r_ones <= 4'd9;
            end
          end else if (r_press[0] && (r_code <= 4'd9)) begin
            r_mins <= r_tens;
            r_tens <= r_ones;
            r_ones <= r_code;
          end
        end
        S_LOAD0: begin
          r_data  <= r_tens;
          r_state <= S_LOAD1;
        end
        S_LOAD1: begin
          r_data  <= r_ones;
          r_state <= S_LOAD2;
        end
        S_LOAD2: begin
          r_loadn     <= 1'b1;
          r_data      <= 4'd0;
          r_loading   <= 1'b0;
          r_load_done <= 1'b1;
          r_mins      <= 4'd0;
          r_tens      <= 4'd0;
          r_ones      <= 4'd0;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_load_done <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_loadn     <= 1'b1;
          r_data      <= 4'd0;
          r_loading   <= 1'b0;
          r_load_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data       = r_data;
  assign bus.loadn      = r_loadn;
  assign bus.entry_mins = r_mins;
  assign bus.entry_tens = r_tens;
  assign bus.entry_ones = r_ones;
  assign bus.loading    = r_loading;
  assign bus.load_done  = r_load_done;

endmodule

// File: tb/tb_keypad_time_loader.sv
// Randomized bench for keypad_time_loader: a behavioural model of the keypad
// entry and load sequence is compared against the DUT outputs every clock.
module tb_keypad_time_loader;
  localparam int DB = 4;

  logic clock = 1'b0;
  logic clrn  = 1'b0;

  keypad_time_loader_if bus ();

  keypad_time_loader #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clock (clock),
    .clrn  (clrn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: per-key sample history, debounced level, pending press, entry and load phase.
  bit   hist [3][DB];
  int   nsamp [3];
  bit   mlvl [3];
  bit   pend [3];
  int   pcode;
  int   phase;       // 0 idle, 1..3 digit being loaded, 4 done pulse
  int   ent [3];     // mins, tens, ones
  bit   mon_en = 1'b0;
  int   lo_cycles;
  int   done_cycles;
  int   ldq [$];
  logic [18:0] act_v;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      nsamp[k] = 0;
      mlvl[k]  = 1'b0;
      pend[k]  = 1'b0;
      ent[k]   = 0;
      for (int j = 0; j < DB; j++) hist[k][j] = 1'b0;
    end
    pcode = 0;
    phase = 0;
  endtask

  task automatic model_step();
    bit s [3];
    bit now_p [3];
    bit same;
    s[0] = bus.key_down;
    s[1] = bus.start_key;
    s[2] = bus.clear_key;
    for (int k = 0; k < 3; k++) begin
      for (int j = DB - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = s[k];
      if (nsamp[k] < DB) nsamp[k]++;
      now_p[k] = 1'b0;
      if (nsamp[k] == DB) begin
        same = 1'b1;
        for (int j = 0; j < DB; j++) if (hist[k][j] != s[k]) same = 1'b0;
        if (same && (mlvl[k] != s[k])) begin
          mlvl[k]  = s[k];
          now_p[k] = s[k];
        end
      end
    end
    if (phase == 0) begin
      if (pend[2]) begin
        ent[0] = 0; ent[1] = 0; ent[2] = 0;
      end else if (pend[1] && (ent[0] + ent[1] + ent[2] != 0)) begin
        if (ent[1] > 5) begin ent[1] = 5; ent[2] = 9; end
        phase = 1;
      end else if (pend[0] && pcode <= 9) begin
        ent[0] = ent[1]; ent[1] = ent[2]; ent[2] = pcode;
      end
    end else if (phase == 4) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == 4) begin ent[0] = 0; ent[1] = 0; ent[2] = 0; end
    end
    for (int k = 0; k < 3; k++) pend[k] = now_p[k];
    if (now_p[0]) pcode = int'(bus.key_code);
  endtask

  function automatic logic [18:0] model_out();
    bit ld;
    logic [3:0] d;
    ld = (phase >= 1) && (phase <= 3);
    d  = ld ? 4'(ent[phase-1]) : 4'd0;
    return {d, ~ld, 4'(ent[0]), 4'(ent[1]), 4'(ent[2]), ld, (phase == 4)};
  endfunction

  // Model update at every active edge, DUT compare 1 time unit later.
  always @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      model_reset();
    end else begin
      model_step();
      #1;
      if (mon_en && clrn) begin
        act_v = {bus.data, bus.loadn, bus.entry_mins, bus.entry_tens, bus.entry_ones,
                 bus.loading, bus.load_done};
        chk("cycle_outputs", int'(act_v), int'(model_out()));
        if (!bus.loadn) begin ldq.push_back(int'(bus.data)); lo_cycles++; end
        if (bus.load_done) done_cycles++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic digit(input int c);
    bus.key_code = 4'(c);
    bus.key_down = 1'b1;
    tick(6);
    bus.key_down = 1'b0;
    tick(6);
  endtask

  task automatic press_start();
    bus.start_key = 1'b1;
    tick(6);
    bus.start_key = 1'b0;
    tick(8);
  endtask

  task automatic press_clear();
    bus.clear_key = 1'b1;
    tick(6);
    bus.clear_key = 1'b0;
    tick(6);
  endtask

  task automatic check_entry(input string name, input int m, input int t, input int o);
    chk({name, "_dut"}, int'({bus.entry_mins, bus.entry_tens, bus.entry_ones}), m*256 + t*16 + o);
    chk({name, "_model"}, ent[0]*256 + ent[1]*16 + ent[2], m*256 + t*16 + o);
  endtask

  function automatic int qpack();
    if (ldq.size() != 3) return -1;
    return ldq[0]*256 + ldq[1]*16 + ldq[2];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_code  = 4'd0;
    bus.key_down  = 1'b0;
    bus.start_key = 1'b0;
    bus.clear_key = 1'b0;
    lo_cycles     = 0;
    done_cycles   = 0;
    clrn          = 1'b0;
    tick(3);
    chk("reset_outputs", int'({bus.data, bus.loadn, bus.loading, bus.load_done}), 4);
    check_entry("reset_entry", 0, 0, 0);
    clrn   = 1'b1;
    mon_en = 1'b1;
    tick(2);

    // Entry 1:30 and load
    digit(1); digit(3); digit(0);
    check_entry("entry_130", 1, 3, 0);
    ldq.delete(); lo_cycles = 0; done_cycles = 0;
    press_start();
    chk("load_seq_130", qpack(), 'h130);
    chk("loadn_low_cycles", lo_cycles, 3);
    chk("load_done_pulses", done_cycles, 1);
    check_entry("entry_after_load", 0, 0, 0);

    // Bounce rejection then invalid code
    bus.key_code = 4'd7;
    for (int i = 0; i < 3; i++) begin
      bus.key_down = 1'b1; tick(2);
      bus.key_down = 1'b0; tick(2);
    end
    bus.key_down = 1'b1; tick(6);
    bus.key_down = 1'b0; tick(6);
    check_entry("bounce_single_7", 0, 0, 7);
    digit(12);
    check_entry("invalid_code", 0, 0, 7);
    press_clear();
    check_entry("clear", 0, 0, 0);

    // Clamp and overflow
    digit(2); digit(8); digit(4);
    check_entry("entry_284", 2, 8, 4);
    ldq.delete();
    press_start();
    chk("clamp_seq_259", qpack(), 'h259);
    digit(1); digit(2); digit(3); digit(4);
    check_entry("overflow_234", 2, 3, 4);
    press_clear();

    // Zero start is ignored
    lo_cycles = 0;
    press_start();
    chk("zero_start_no_load", lo_cycles, 0);

    // Clear beats Start in the same cycle
    digit(4); digit(5);
    check_entry("entry_045", 0, 4, 5);
    bus.clear_key = 1'b1; bus.start_key = 1'b1;
    tick(6);
    bus.clear_key = 1'b0; bus.start_key = 1'b0;
    tick(8);
    check_entry("clear_over_start", 0, 0, 0);
    chk("clear_over_start_no_load", lo_cycles, 0);

    // Digit debounced while LOAD1 is active is dropped
    digit(1); digit(2);
    ldq.delete();
    bus.start_key = 1'b1;
    tick(2);
    bus.key_code = 4'd9; bus.key_down = 1'b1;
    tick(4);
    bus.start_key = 1'b0;
    tick(4);
    bus.key_down = 1'b0;
    tick(10);
    chk("busy_seq_012", qpack(), 'h012);
    check_entry("digit_ignored_in_load", 0, 0, 0);

    // Reset during LOAD1
    digit(5); digit(6);
    bus.start_key = 1'b1;
    for (int i = 0; i < 20 && bus.loadn; i++) tick(1);
    chk("reach_load0", int'(bus.loadn), 0);
    tick(1);
    chk("load1_data", int'(bus.data), 5);
    clrn = 1'b0;
    #1;
    chk("async_loadn", int'(bus.loadn), 1);
    chk("async_data", int'(bus.data), 0);
    chk("async_loading", int'(bus.loading), 0);
    bus.start_key = 1'b0;
    tick(3);
    done_cycles = 0;
    clrn = 1'b1;
    tick(12);
    check_entry("after_reset", 0, 0, 0);
    chk("no_done_after_reset", done_cycles, 0);

    // Random key activity, model checked every cycle
    for (int it = 0; it < 150; it++) begin
      int sel;
      sel = int'($urandom_range(0, 5));
      bus.key_code = 4'($urandom_range(0, 15));
      if (sel <= 2 || sel == 5) bus.key_down = 1'b1;
      if (sel == 3) bus.start_key = 1'b1;
      if (sel == 4 && ($urandom_range(0, 3) == 0)) bus.clear_key = 1'b1;
      tick(int'($urandom_range(1, 8)));
      bus.key_down  = 1'b0;
      bus.start_key = 1'b0;
      bus.clear_key = 1'b0;
      tick(int'($urandom_range(1, 8)));
    end
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
